// File: rtl/ex_mem_pipe_if.sv
// EX/MEM handshake bundle: EX-side beat input, MEM-side beat output, flush and occupancy.
// The master side drives the EX beat, flush and out_ready_i; the slave side is the pipe stage.
interface ex_mem_pipe_if #(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned RADDR_W = 5
);
    logic               in_valid_i;
    logic               in_ready_o;
    logic [DATA_W-1:0]  alu_out_i;
    logic [DATA_W-1:0]  store_data_i;
    logic [RADDR_W-1:0] rd_addr_i;
    logic               mem_rd_i;
    logic               mem_wr_i;
    logic               mem_to_reg_i;
    logic               reg_wr_i;
    logic               flush_i;
    logic               out_valid_o;
    logic               out_ready_i;
    logic [DATA_W-1:0]  alu_out_o;
    logic [DATA_W-1:0]  store_data_o;
    logic [RADDR_W-1:0] rd_addr_o;
    logic               mem_rd_o;
    logic               mem_wr_o;
    logic               mem_to_reg_o;
    logic               reg_wr_o;
    logic [1:0]         occupancy_o;

    modport master (
        output in_valid_i, alu_out_i, store_data_i, rd_addr_i,
               mem_rd_i, mem_wr_i, mem_to_reg_i, reg_wr_i, flush_i, out_ready_i,
        input  in_ready_o, out_valid_o, alu_out_o, store_data_o, rd_addr_o,
               mem_rd_o, mem_wr_o, mem_to_reg_o, reg_wr_o, occupancy_o
    );

    modport slave (
        input  in_valid_i, alu_out_i, store_data_i, rd_addr_i,
               mem_rd_i, mem_wr_i, mem_to_reg_i, reg_wr_i, flush_i, out_ready_i,
        output in_ready_o, out_valid_o, alu_out_o, store_data_o, rd_addr_o,
               mem_rd_o, mem_wr_o, mem_to_reg_o, reg_wr_o, occupancy_o
    );
endinterface

// File: rtl/ex_mem_pipe.sv
// EX/MEM pipeline stage with valid/ready handshake, flush and bubble-gated controls.
// Define EX_MEM_SKID_EN for a 2-entry skid buffer with a registered in_ready_o.
module ex_mem_pipe #(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned RADDR_W = 5
) (
    input  logic          clk_i,
    input  logic          rst_i,
    ex_mem_pipe_if.slave  bus
);
    typedef struct packed {
        logic [DATA_W-1:0]  alu_out;
        logic [DATA_W-1:0]  store_data;
        logic [RADDR_W-1:0] rd_addr;
        logic               mem_rd;
        logic               mem_wr;
        logic               mem_to_reg;
        logic               reg_wr;
    } beat_t;

    beat_t      in_beat;
    beat_t      head_q;
    beat_t      head_d;
    logic       head_valid_q;
    logic       head_valid_d;
    logic       in_ready;
    logic       accept;
    logic       deliver;
    logic [1:0] occ_q;
    logic [1:0] occ_d;

    always_comb begin
        in_beat            = '0;
        in_beat.alu_out    = bus.alu_out_i;
        in_beat.store_data = bus.store_data_i;
        in_beat.rd_addr    = bus.rd_addr_i;
        in_beat.mem_rd     = bus.mem_rd_i;
        in_beat.mem_wr     = bus.mem_wr_i;
        in_beat.mem_to_reg = bus.mem_to_reg_i;
        in_beat.reg_wr     = bus.reg_wr_i;
    end

    // Flush wins over accept; a delivery in the flush cycle still happens.
    assign accept  = bus.in_valid_i & in_ready & ~bus.flush_i;
    assign deliver = head_valid_q & bus.out_ready_i;

`ifdef EX_MEM_SKID_EN
    beat_t skid_q;
    beat_t skid_d;
    logic  skid_valid_q;
    logic  skid_valid_d;
    logic  ready_q;

    assign in_ready = ready_q;

    always_comb begin
        head_d       = head_q;
        head_valid_d = head_valid_q;
        skid_d       = skid_q;
        skid_valid_d = skid_valid_q;
        if (bus.flush_i) begin
            head_valid_d = 1'b0;
            skid_valid_d = 1'b0;
        end else if (deliver) begin
            // in_ready is low whenever skid is full, so skid refill never collides with accept
            if (skid_valid_q) begin
                head_d       = skid_q;
                skid_valid_d = 1'b0;
            end else if (accept) begin
                head_d = in_beat;
            end else begin
                head_valid_d = 1'b0;
            end
        end else if (accept) begin
            if (head_valid_q) begin
                skid_d       = in_beat;
                skid_valid_d = 1'b1;
            end else begin
                head_d       = in_beat;
                head_valid_d = 1'b1;
            end
        end
        if (!head_valid_d) begin
            {head_d.mem_rd, head_d.mem_wr, head_d.mem_to_reg, head_d.reg_wr} = 4'b0000;
        end
    end

    assign occ_d = {skid_valid_d, head_valid_d & ~skid_valid_d};

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            skid_q       <= '0;
            skid_valid_q <= 1'b0;
            ready_q      <= 1'b1;
        end else begin
            skid_q       <= skid_d;
            skid_valid_q <= skid_valid_d;
            ready_q      <= ~skid_valid_d;
        end
    end
`else
    assign in_ready = ~head_valid_q | bus.out_ready_i;

    always_comb begin
        head_d       = head_q;
        head_valid_d = head_valid_q;
        if (bus.flush_i) begin
            head_valid_d = 1'b0;
        end else if (accept) begin
            head_d       = in_beat;
            head_valid_d = 1'b1;
        end else if (deliver) begin
            head_valid_d = 1'b0;
        end
        if (!head_valid_d) begin
            {head_d.mem_rd, head_d.mem_wr, head_d.mem_to_reg, head_d.reg_wr} = 4'b0000;
        end
    end

    assign occ_d = {1'b0, head_valid_d};
`endif

    // Head register: controls are stored pre-gated so a bubble never carries a write.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            head_q       <= '0;
            head_valid_q <= 1'b0;
            occ_q        <= 2'b00;
        end else begin
            head_q       <= head_d;
            head_valid_q <= head_valid_d;
            occ_q        <= occ_d;
        end
    end

    assign bus.in_ready_o   = in_ready;
    assign bus.out_valid_o  = head_valid_q;
    assign bus.alu_out_o    = head_q.alu_out;
    assign bus.store_data_o = head_q.store_data;
    assign bus.rd_addr_o    = head_q.rd_addr;
    assign bus.mem_rd_o     = head_q.mem_rd;
    assign bus.mem_wr_o     = head_q.mem_wr;
    assign bus.mem_to_reg_o = head_q.mem_to_reg;
    assign bus.reg_wr_o     = head_q.reg_wr;
    assign bus.occupancy_o  = occ_q;
endmodule

// File: tb/tb_ex_mem_pipe.sv
// Self-checking bench for ex_mem_pipe: queue-based model plus directed and random traffic,
// and a 64-bit / 6-bit-address instance for the width sweep.
module tb_ex_mem_pipe;
`ifdef EX_MEM_SKID_EN
    localparam int CAP = 2;
`else
    localparam int CAP = 1;
`endif

    typedef struct packed {
        logic [31:0] alu;
        logic [31:0] sd;
        logic [4:0]  rd;
        logic [3:0]  ctrl;   // {mem_rd, mem_wr, mem_to_reg, reg_wr}
    } tbeat_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rst_w = 1'b1;
    always #5 clk = ~clk;

    ex_mem_pipe_if #(.DATA_W(32), .RADDR_W(5)) bus ();
    ex_mem_pipe_if #(.DATA_W(64), .RADDR_W(6)) wbus ();

    ex_mem_pipe #(.DATA_W(32), .RADDR_W(5)) dut (.clk_i(clk), .rst_i(rst), .bus(bus));
    ex_mem_pipe #(.DATA_W(64), .RADDR_W(6)) dut_w (.clk_i(clk), .rst_i(rst_w), .bus(wbus));

    tbeat_t q[$];
    tbeat_t last;
    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
        n_chk++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, want, $time);
        end
    endtask

    function automatic tbeat_t mk(input logic [31:0] alu, input logic [31:0] sd,
                                  input logic [4:0] rd, input logic [3:0] ctrl);
        tbeat_t b;
        b.alu = alu; b.sd = sd; b.rd = rd; b.ctrl = ctrl;
        return b;
    endfunction

    // Head of the model queue is what MEM must see; payload holds when empty.
    task automatic compare_outputs();
        tbeat_t h;
        logic [3:0] c;
        h = (q.size() != 0) ? q[0] : last;
        c = (q.size() != 0) ? q[0].ctrl : 4'b0000;
        chk("out_valid", 64'(bus.out_valid_o), 64'(q.size() != 0));
        chk("alu_out", 64'(bus.alu_out_o), 64'(h.alu));
        chk("store_data", 64'(bus.store_data_o), 64'(h.sd));
        chk("rd_addr", 64'(bus.rd_addr_o), 64'(h.rd));
        chk("ctrl", 64'({bus.mem_rd_o, bus.mem_wr_o, bus.mem_to_reg_o, bus.reg_wr_o}), 64'(c));
        chk("occupancy", 64'(bus.occupancy_o), 64'(q.size()));
    endtask

    // One clock: drive at negedge, check ready, advance model, check outputs at next negedge.
    task automatic cycle(input logic r, input logic fl, input logic iv, input logic ordy,
                         input tbeat_t b);
        logic want_rdy;
        logic acc;
        rst = r;
        bus.flush_i = fl;
        bus.in_valid_i = iv;
        bus.out_ready_i = ordy;
        bus.alu_out_i = b.alu;
        bus.store_data_i = b.sd;
        bus.rd_addr_i = b.rd;
        {bus.mem_rd_i, bus.mem_wr_i, bus.mem_to_reg_i, bus.reg_wr_i} = b.ctrl;
        #1;
        want_rdy = (CAP == 2) ? (q.size() < 2) : (q.size() == 0 || ordy);
        if (!r) chk("in_ready", 64'(bus.in_ready_o), 64'(want_rdy));
        if (r) begin
            q.delete();
            last = '0;
        end else begin
            acc = iv && want_rdy && !fl;
            if (q.size() != 0) last = q[0];
            if (q.size() != 0 && ordy) void'(q.pop_front());
            if (fl) q.delete();
            else if (acc) q.push_back(b);
            if (q.size() != 0) last = q[0];
        end
        @(posedge clk);
        @(negedge clk);
        compare_outputs();
    endtask

    task automatic fill_stalled();
        for (int i = 0; i < CAP; i++) begin
            cycle(1'b0, 1'b0, 1'b1, 1'b0, mk(32'hA000_0000 + 32'(i), 32'h5A5A_0000 + 32'(i), 5'(i + 3), 4'b1011));
        end
    endtask

    initial begin
        tbeat_t nb;
        logic [63:0] wv [2];
        nb = '0;
        last = '0;
        wbus.in_valid_i = 1'b0; wbus.flush_i = 1'b0; wbus.out_ready_i = 1'b1;
        wbus.alu_out_i = '0; wbus.store_data_i = '0; wbus.rd_addr_i = '0;
        wbus.mem_rd_i = 1'b0; wbus.mem_wr_i = 1'b0; wbus.mem_to_reg_i = 1'b0; wbus.reg_wr_i = 1'b0;
        @(negedge clk);

        // Reset for two cycles, then stream four beats
        cycle(1'b1, 1'b0, 1'b0, 1'b1, nb);
        cycle(1'b1, 1'b0, 1'b0, 1'b1, nb);
        chk("reset_valid", 64'(bus.out_valid_o), 64'd0);
        for (int i = 0; i < 4; i++) begin
            cycle(1'b0, 1'b0, 1'b1, 1'b1, mk(32'((i + 1) * 16), 32'h0, 5'd1, 4'b0001));
            chk("stream_alu", 64'(bus.alu_out_o), 64'((i + 1) * 16));
            chk("stream_valid", 64'(bus.out_valid_o), 64'd1);
        end
        cycle(1'b0, 1'b0, 1'b0, 1'b1, nb);

        // Backpressure
        cycle(1'b0, 1'b0, 1'b1, 1'b1, mk(32'h111, 32'h1, 5'd1, 4'b0001));
        cycle(1'b0, 1'b0, 1'b1, 1'b0, mk(32'h222, 32'h2, 5'd2, 4'b0001));
`ifdef EX_MEM_SKID_EN
        chk("bp_occ2", 64'(bus.occupancy_o), 64'd2);
        chk("bp_ready0", 64'(bus.in_ready_o), 64'd0);
`else
        bus.out_ready_i = 1'b1; #1;
        chk("bp_ready_follow1", 64'(bus.in_ready_o), 64'd1);
        bus.out_ready_i = 1'b0; #1;
        chk("bp_ready_follow0", 64'(bus.in_ready_o), 64'd0);
`endif
        cycle(1'b0, 1'b0, 1'b1, 1'b0, mk(32'h333, 32'h3, 5'd3, 4'b0001));
        cycle(1'b0, 1'b0, 1'b1, 1'b0, mk(32'h333, 32'h3, 5'd3, 4'b0001));
        cycle(1'b0, 1'b0, 1'b0, 1'b1, nb);
`ifdef EX_MEM_SKID_EN
        chk("bp_order", 64'(bus.alu_out_o), 64'h222);
`endif
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 1'b0, 1'b1, nb);

        // Flush colliding with an offered store
        fill_stalled();
        cycle(1'b0, 1'b1, 1'b1, 1'b0, mk(32'hDEAD, 32'hBEEF, 5'd9, 4'b0100));
        chk("flush_occ", 64'(bus.occupancy_o), 64'd0);
        chk("flush_valid", 64'(bus.out_valid_o), 64'd0);
        chk("flush_mem_wr", 64'(bus.mem_wr_o), 64'd0);
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 1'b0, 1'b1, nb);

        // Bubble gating
        cycle(1'b0, 1'b0, 1'b1, 1'b0, mk(32'h77, 32'h88, 5'd7, 4'b0001));
        cycle(1'b0, 1'b0, 1'b0, 1'b1, nb);
        chk("bubble_reg_wr", 64'(bus.reg_wr_o), 64'd0);
        chk("bubble_rd_hold", 64'(bus.rd_addr_o), 64'd7);

        // Reset in the middle of a stall
        fill_stalled();
        cycle(1'b1, 1'b0, 1'b1, 1'b0, mk(32'h1234, 32'h5678, 5'd4, 4'b1111));
        chk("rst_occ", 64'(bus.occupancy_o), 64'd0);
        chk("rst_alu", 64'(bus.alu_out_o), 64'd0);
        chk("rst_sd", 64'(bus.store_data_o), 64'd0);
        chk("rst_valid", 64'(bus.out_valid_o), 64'd0);
        chk("rst_ready", 64'(bus.in_ready_o), 64'd1);

        // Random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            cycle(($urandom_range(0, 149) == 0), ($urandom_range(0, 19) == 0),
                  ($urandom_range(0, 9) < 7), ($urandom_range(0, 9) < 6),
                  mk($urandom, $urandom, 5'($urandom_range(0, 31)), 4'($urandom_range(0, 15))));
        end

        // Width sweep on the 64-bit instance
        rst_w = 1'b1;
        @(posedge clk); @(posedge clk); @(negedge clk);
        rst_w = 1'b0;
        chk("wide_reset_valid", 64'(wbus.out_valid_o), 64'd0);
        wv[0] = 64'hFFFF_FFFF_0000_0001;
        wv[1] = 64'h0123_4567_89AB_CDEF;
        for (int i = 0; i < 2; i++) begin
            wbus.in_valid_i = 1'b1;
            wbus.alu_out_i = wv[i];
            wbus.store_data_i = ~wv[i];
            wbus.rd_addr_i = 6'(63 - i);
            wbus.reg_wr_i = 1'b1;
            @(posedge clk); @(negedge clk);
            chk("wide_alu", wbus.alu_out_o, wv[i]);
            chk("wide_sd", wbus.store_data_o, ~wv[i]);
            chk("wide_rd", 64'(wbus.rd_addr_o), 64'(63 - i));
            chk("wide_valid", 64'(wbus.out_valid_o), 64'd1);
        end
        wbus.in_valid_i = 1'b0;
        @(posedge clk); @(negedge clk);
        chk("wide_drain", 64'(wbus.out_valid_o), 64'd0);
        chk("wide_bubble_reg_wr", 64'(wbus.reg_wr_o), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
